// File: rtl/clic_pkg.sv
// Shared CLIC types: trigger mode and polarity encodings used by the
// gateway and the configuration register file.
package clic_pkg;

    typedef enum logic {
        TRIG_LEVEL = 1'b0,
        TRIG_EDGE  = 1'b1
    } trig_e;

    typedef enum logic {
        POL_POS = 1'b0,
        POL_NEG = 1'b1
    } pol_e;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/clic_gateway_cell.sv
// One interrupt source: synchroniser chain, active-value history flop and
// the pending bit. Edge mode gives set priority over any clear so an edge
// arriving with a claim is never lost.
module clic_gateway_cell
    import clic_pkg::*;
#(
    parameter int unsigned SyncStages = DEFAULT_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_src,
    input  logic i_edge,
    input  logic i_pol,
    input  logic i_claim,
    input  logic i_sw_we,
    input  logic i_sw_wdata,
    output logic o_ip
);

    logic [SyncStages-1:0] r_sync;
    logic [SyncStages:0]   w_shift;
    logic                  r_prev;
    logic                  r_ip;
    logic                  w_active;
    logic                  w_edge;
    logic                  w_ip_next;
    trig_e                 w_trig;
    pol_e                  w_pol;

    assign w_trig   = trig_e'(i_edge);
    assign w_pol    = pol_e'(i_pol);
    // Raw line enters at bit 0; the top bit is the synchronised value.
    assign w_shift  = {r_sync, i_src};
    assign w_active = w_shift[SyncStages] ^ (w_pol == POL_NEG);
    assign w_edge   = w_active & ~r_prev;

    // Synchroniser shift and active-value history, tracked in both modes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= w_shift[SyncStages-1:0];
            r_prev <= w_active;
        end
    end

    // Pending-bit next state: level follows the line, edge uses set-over-clear priority.
    always_comb begin
        w_ip_next = r_ip;
        if (w_trig == TRIG_LEVEL) begin
            w_ip_next = w_active;
        end else if (w_edge) begin
            w_ip_next = 1'b1;
        end else if (i_sw_we) begin
            w_ip_next = i_sw_wdata;
        end else if (i_claim) begin
            w_ip_next = 1'b0;
        end
    end

    // Pending-bit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ip <= 1'b0;
        end else begin
            r_ip <= w_ip_next;
        end
    end

    assign o_ip = r_ip;

endmodule

// File: rtl/clic_gateway.sv
// Per-source interrupt gateway array. Decodes the software write index into
// a one-hot strobe (out-of-range indices match no cell) and replicates the
// gateway cell once per source.
module clic_gateway
    import clic_pkg::*;
#(
    parameter  int unsigned N_SOURCE   = 256,
    parameter  int unsigned SyncStages = DEFAULT_SYNC_STAGES,
    localparam int unsigned SrcWidth   = $clog2(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] intr_src_i,
    input  logic [N_SOURCE-1:0] trig_edge_i,
    input  logic [N_SOURCE-1:0] trig_pol_i,
    input  logic [N_SOURCE-1:0] claim_i,
    input  logic                sw_we_i,
    input  logic [SrcWidth-1:0] sw_id_i,
    input  logic                sw_wdata_i,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] le_o
);

    logic [N_SOURCE-1:0] w_sw_we;
    logic [N_SOURCE-1:0] w_ip;

    for (genvar g = 0; g < N_SOURCE; g++) begin : g_cell
        assign w_sw_we[g] = sw_we_i & (sw_id_i == SrcWidth'(g));

        clic_gateway_cell #(
            .SyncStages (SyncStages)
        ) u_cell (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .i_src      (intr_src_i[g]),
            .i_edge     (trig_edge_i[g]),
            .i_pol      (trig_pol_i[g]),
            .i_claim    (claim_i[g]),
            .i_sw_we    (w_sw_we[g]),
            .i_sw_wdata (sw_wdata_i),
            .o_ip       (w_ip[g])
        );
    end

    assign ip_o = w_ip;
    assign le_o = trig_edge_i;

    a_min_sources : assert property (@(posedge clk_i) N_SOURCE >= 2);
    a_min_sync    : assert property (@(posedge clk_i) SyncStages >= 1);
    a_claim_1hot  : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(claim_i));

endmodule

// File: tb/tb_clic_gateway.sv
// Bench for clic_gateway: a table of per-cycle stimulus with hand-derived
// expected pending bits, checked through an expectation queue one clock later,
// followed by a hand-written reset-while-pending sequence.
module tb_clic_gateway;

    localparam int unsigned N  = 20;
    localparam int unsigned SW = 5;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  intr_src_i;
    logic [N-1:0]  trig_edge_i;
    logic [N-1:0]  trig_pol_i;
    logic [N-1:0]  claim_i;
    logic          sw_we_i;
    logic [SW-1:0] sw_id_i;
    logic          sw_wdata_i;
    logic [N-1:0]  ip_o;
    logic [N-1:0]  le_o;

    clic_gateway #(
        .N_SOURCE   (N),
        .SyncStages (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .intr_src_i  (intr_src_i),
        .trig_edge_i (trig_edge_i),
        .trig_pol_i  (trig_pol_i),
        .claim_i     (claim_i),
        .sw_we_i     (sw_we_i),
        .sw_id_i     (sw_id_i),
        .sw_wdata_i  (sw_wdata_i),
        .ip_o        (ip_o),
        .le_o        (le_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string         name;
        logic [N-1:0]  src;
        logic [N-1:0]  edg;
        logic [N-1:0]  pol;
        logic [N-1:0]  claim;
        logic          swe;
        logic [SW-1:0] id;
        logic          wd;
        logic [N-1:0]  mask;
        logic [N-1:0]  exp;
    } vec_t;

    typedef struct {
        string        name;
        logic [N-1:0] mask;
        logic [N-1:0] exp;
        logic [N-1:0] le;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    localparam logic [N-1:0] E    = 20'h012A0;  // edge sources 5,7,9,12
    localparam logic [N-1:0] P    = 20'h00088;  // negative polarity on 3,7
    localparam logic [N-1:0] ALL  = '1;
    localparam logic [N-1:0] NONE = '0;

    function automatic vec_t mk(input string name, input logic [N-1:0] src,
                                input logic [N-1:0] edg, input logic [N-1:0] claim,
                                input logic swe, input logic [SW-1:0] id, input logic wd,
                                input logic [N-1:0] mask, input logic [N-1:0] exp);
        vec_t v;
        v.name  = name;
        v.src   = src;
        v.edg   = edg;
        v.pol   = P;
        v.claim = claim;
        v.swe   = swe;
        v.id    = id;
        v.wd    = wd;
        v.mask  = mask;
        v.exp   = exp;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = exp_q.pop_front();
        n_chk++;
        if ((ip_o & e.mask) === e.exp) n_pass++;
        else $display("FAIL %s: ip_o=%h masked=%h required=%h (mask %h)",
                      e.name, ip_o, ip_o & e.mask, e.exp, e.mask);
        n_chk++;
        if (le_o === e.le) n_pass++;
        else $display("FAIL %s_le: le_o=%h required=%h", e.name, le_o, e.le);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        intr_src_i  = v.src;
        trig_edge_i = v.edg;
        trig_pol_i  = v.pol;
        claim_i     = v.claim;
        sw_we_i     = v.swe;
        sw_id_i     = v.id;
        sw_wdata_i  = v.wd;
        e.name = v.name;
        e.mask = v.mask;
        e.exp  = v.exp;
        e.le   = v.edg;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        check_out();
    endtask

    initial begin
        vec_t v;
        exp_t e;

        // Settle: id7 (falling, line high) and id3 (level, active-low, line low)
        // see an active value right after reset; id7 is then claimed away.
        vecs.push_back(mk("settle0", 20'h00080, E, NONE, 0, 0, 0, ALL, 20'h00088));
        vecs.push_back(mk("settle1", 20'h00080, E, NONE, 0, 0, 0, ALL, 20'h00088));
        vecs.push_back(mk("settle2", 20'h00080, E, NONE, 0, 0, 0, ALL, 20'h00088));
        vecs.push_back(mk("settle_claim7", 20'h00080, E, 20'h00080, 0, 0, 0, ALL, 20'h00008));
        // Rising edge on id5, hold, claim, no re-set.
        vecs.push_back(mk("rise5_c1", 20'h000A0, E, NONE, 0, 0, 0, 20'h20, 20'h00));
        vecs.push_back(mk("rise5_c2", 20'h000A0, E, NONE, 0, 0, 0, 20'h20, 20'h00));
        vecs.push_back(mk("rise5_c3", 20'h000A0, E, NONE, 0, 0, 0, 20'h20, 20'h20));
        vecs.push_back(mk("rise5_hold", 20'h000A0, E, NONE, 0, 0, 0, 20'h20, 20'h20));
        vecs.push_back(mk("rise5_claim", 20'h000A0, E, 20'h00020, 0, 0, 0, 20'h20, 20'h00));
        vecs.push_back(mk("rise5_noreset", 20'h000A0, E, NONE, 0, 0, 0, 20'h20, 20'h00));
        // Falling edge on id7, then rising line must not set.
        vecs.push_back(mk("fall7_c1", 20'h00020, E, NONE, 0, 0, 0, 20'h80, 20'h00));
        vecs.push_back(mk("fall7_c2", 20'h00020, E, NONE, 0, 0, 0, 20'h80, 20'h00));
        vecs.push_back(mk("fall7_c3", 20'h00020, E, NONE, 0, 0, 0, 20'h80, 20'h80));
        vecs.push_back(mk("fall7_claim", 20'h00020, E, 20'h00080, 0, 0, 0, 20'h80, 20'h00));
        vecs.push_back(mk("rise7_c1", 20'h000A0, E, NONE, 0, 0, 0, 20'h80, 20'h00));
        vecs.push_back(mk("rise7_c2", 20'h000A0, E, NONE, 0, 0, 0, 20'h80, 20'h00));
        vecs.push_back(mk("rise7_c3", 20'h000A0, E, NONE, 0, 0, 0, 20'h80, 20'h00));
        // Level id3 (active-low): claim and sw clear ignored; follows the line.
        vecs.push_back(mk("lvl3_ignore", 20'h000A0, E, 20'h00008, 1, 5'd3, 0, 20'h08, 20'h08));
        vecs.push_back(mk("lvl3_off_c1", 20'h000A8, E, NONE, 0, 0, 0, 20'h08, 20'h08));
        vecs.push_back(mk("lvl3_off_c2", 20'h000A8, E, NONE, 0, 0, 0, 20'h08, 20'h08));
        vecs.push_back(mk("lvl3_off_c3", 20'h000A8, E, NONE, 0, 0, 0, 20'h08, 20'h00));
        vecs.push_back(mk("lvl3_on_c1", 20'h000A0, E, NONE, 0, 0, 0, 20'h08, 20'h00));
        vecs.push_back(mk("lvl3_on_c2", 20'h000A0, E, NONE, 0, 0, 0, 20'h08, 20'h00));
        vecs.push_back(mk("lvl3_on_c3", 20'h000A0, E, NONE, 0, 0, 0, 20'h08, 20'h08));
        // Collisions on id9.
        vecs.push_back(mk("col9_c1", 20'h002A0, E, NONE, 0, 0, 0, 20'h200, 20'h000));
        vecs.push_back(mk("col9_c2", 20'h002A0, E, NONE, 0, 0, 0, 20'h200, 20'h000));
        vecs.push_back(mk("col9_edge_claim", 20'h002A0, E, 20'h00200, 0, 0, 0, 20'h200, 20'h200));
        vecs.push_back(mk("col9_sw1_claim", 20'h002A0, E, 20'h00200, 1, 5'd9, 1, 20'h200, 20'h200));
        vecs.push_back(mk("col9_sw0", 20'h002A0, E, NONE, 1, 5'd9, 0, 20'h200, 20'h000));
        vecs.push_back(mk("col9_hold", 20'h002A0, E, NONE, 0, 0, 0, 20'h200, 20'h000));
        // Software writes, including an out-of-range index.
        vecs.push_back(mk("sw12_set", 20'h002A0, E, NONE, 1, 5'd12, 1, 20'h1000, 20'h1000));
        vecs.push_back(mk("sw_id25_noeffect", 20'h002A0, E, NONE, 1, 5'd25, 1, ALL, 20'h01008));
        vecs.push_back(mk("sw12_clr", 20'h002A0, E, NONE, 1, 5'd12, 0, ALL, 20'h00008));
        // Mode switches on id5 with the line held active.
        vecs.push_back(mk("mode5_to_level", 20'h002A0, 20'h01280, NONE, 0, 0, 0, 20'h20, 20'h20));
        vecs.push_back(mk("mode5_to_edge_hold", 20'h002A0, E, NONE, 0, 0, 0, 20'h20, 20'h20));
        vecs.push_back(mk("mode5_claim", 20'h002A0, E, 20'h00020, 0, 0, 0, 20'h20, 20'h00));
        vecs.push_back(mk("mode5_no_set", 20'h002A0, E, NONE, 0, 0, 0, 20'h20, 20'h00));

        rst_ni      = 1'b0;
        intr_src_i  = '0;
        trig_edge_i = '0;
        trig_pol_i  = '0;
        claim_i     = '0;
        sw_we_i     = 1'b0;
        sw_id_i     = '0;
        sw_wdata_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        e.name = "reset_state"; e.mask = ALL; e.exp = '0; e.le = '0;
        exp_q.push_back(e);
        check_out();
        rst_ni = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Fill every pending bit via software writes in edge mode.
        v = mk("all_edge", NONE, ALL, NONE, 0, 0, 0, NONE, NONE);
        v.pol = '0;
        apply(v);
        for (int unsigned i = 0; i < N; i++) begin
            v.name = $sformatf("swfill%0d", i);
            v.swe  = 1'b1;
            v.id   = SW'(i);
            v.wd   = 1'b1;
            v.mask = '0;
            v.mask[i] = 1'b1;
            v.exp  = v.mask;
            apply(v);
        end
        v.name = "all_pending"; v.swe = 1'b0; v.mask = ALL; v.exp = ALL;
        apply(v);

        // Asynchronous reset mid-cycle clears everything at once.
        #2;
        rst_ni     = 1'b0;
        intr_src_i = '1;
        #1;
        e.name = "async_reset_clear"; e.mask = ALL; e.exp = '0; e.le = ALL;
        exp_q.push_back(e);
        check_out();
        @(posedge clk_i);
        #1;
        e.name = "reset_held_clear";
        exp_q.push_back(e);
        check_out();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Line already high after reset: history starts at 0, so an edge is seen.
        v = mk("post_reset_c1", ALL, ALL, NONE, 0, 0, 0, ALL, NONE);
        v.pol = '0;
        apply(v);
        v.name = "post_reset_c2";
        apply(v);
        v.name = "post_reset_c3"; v.exp = ALL;
        apply(v);

        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_leftover: %0d expectations unconsumed", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
